// File: rtl/button_debouncer.sv
// Per-channel debouncer: 2-flop synchronizer, stability-counting FSM, and registered
// clean level with single-cycle rise/fall strobes.
module button_debouncer #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StLow, StToHigh, StHigh, StToLow} state_e;

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CntW-1:0]  cnt_q   [WIDTH];
    logic [CntW-1:0]  cnt_d   [WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= StLow;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q   <= raw_in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StLow: begin
                    if (s2_q[i]) begin
                        // A one-sample filter accepts the new level without a counting state.
                        if (STABLE_CYCLES == 1) begin
                            state_d[i] = StHigh;
                            out_d[i]   = 1'b1;
                            rise_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = StToHigh;
                            cnt_d[i]   = CntOne;
                        end
                    end
                end
                StToHigh: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StLow;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StHigh;
                        out_d[i]   = 1'b1;
                        rise_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StHigh: begin
                    if (!s2_q[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[i] = StLow;
                            out_d[i]   = 1'b0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = StToLow;
                            cnt_d[i]   = CntOne;
                        end
                    end
                end
                StToLow: begin
                    if (s2_q[i]) begin
                        state_d[i] = StHigh;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StLow;
                        out_d[i]   = 1'b0;
                        fall_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StLow;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: a 4-sample debouncer and a 1-sample debouncer, two channels each.
module tb_button_debouncer;

    logic       clk;
    logic       reset;
    logic [1:0] raw4, out4, rise4, fall4;
    logic [1:0] raw1, out1, rise1, fall1;

    int n_checks = 0;
    int n_errors = 0;

    button_debouncer #(.WIDTH(2), .STABLE_CYCLES(4)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw4),
        .out    (out4),
        .rise   (rise4),
        .fall   (fall4)
    );

    button_debouncer #(.WIDTH(2), .STABLE_CYCLES(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw1),
        .out    (out1),
        .rise   (rise1),
        .fall   (fall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on falling edges.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [9:0] bounce;
    logic [1:0] acc_out, acc_rise, acc_fall;

    initial begin
        reset = 1'b0;
        raw4  = 2'b11;
        raw1  = 2'b00;
        bounce = 10'b1111101101;  // bit k applied on cycle k: 1,0,1,1,0,1,1,1,1,1

        // Reset held with inputs high
        tick(3);
        check_eq("rst_out", 32'(out4), 32'h0);
        check_eq("rst_rise", 32'(rise4), 32'h0);
        check_eq("rst_fall", 32'(fall4), 32'h0);
        reset = 1'b1;
        tick(5);
        check_eq("rel_out_e4", 32'(out4), 32'h0);
        tick(1);
        check_eq("rel_out_e5", 32'(out4), 32'h3);
        check_eq("rel_rise_e5", 32'(rise4), 32'h3);
        tick(1);
        check_eq("rel_rise_off", 32'(rise4), 32'h0);
        check_eq("rel_out_hold", 32'(out4), 32'h3);

        // Both channels fall together
        raw4 = 2'b00;
        tick(6);
        check_eq("both_fall_out", 32'(out4), 32'h0);
        check_eq("both_fall", 32'(fall4), 32'h3);
        tick(1);
        check_eq("both_fall_off", 32'(fall4), 32'h0);

        // Clean press on channel 0, held 10 cycles
        raw4 = 2'b01;
        tick(5);
        check_eq("press_out_e4", 32'(out4), 32'h0);
        tick(1);
        check_eq("press_out", 32'(out4), 32'h1);
        check_eq("press_rise", 32'(rise4), 32'h1);
        tick(1);
        check_eq("press_rise_off", 32'(rise4), 32'h0);
        tick(3);

        // Clean release on channel 0
        raw4 = 2'b00;
        tick(5);
        check_eq("release_out_e4", 32'(out4), 32'h1);
        check_eq("release_fall_e4", 32'(fall4), 32'h0);
        tick(1);
        check_eq("release_out", 32'(out4), 32'h0);
        check_eq("release_fall", 32'(fall4), 32'h1);
        tick(1);
        check_eq("release_fall_off", 32'(fall4), 32'h0);
        tick(4);

        // Bounce: only the final run of ones is accepted
        acc_out  = 2'b00;
        acc_rise = 2'b00;
        for (int k = 0; k < 10; k++) begin
            raw4 = {1'b0, bounce[k]};
            tick(1);
            acc_out  = acc_out | out4;
            acc_rise = acc_rise | rise4;
        end
        check_eq("bounce_no_out", 32'(acc_out), 32'h0);
        check_eq("bounce_no_rise", 32'(acc_rise), 32'h0);
        tick(1);
        check_eq("bounce_out", 32'(out4), 32'h1);
        check_eq("bounce_rise", 32'(rise4), 32'h1);
        tick(1);
        check_eq("bounce_rise_off", 32'(rise4), 32'h0);
        raw4 = 2'b00;
        tick(6);
        check_eq("bounce_fall", 32'(fall4), 32'h1);
        tick(4);

        // Three-cycle glitch is filtered out completely
        acc_out  = 2'b00;
        acc_rise = 2'b00;
        acc_fall = 2'b00;
        raw4 = 2'b01;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) raw4 = 2'b00;
            tick(1);
            acc_out  = acc_out | out4;
            acc_rise = acc_rise | rise4;
            acc_fall = acc_fall | fall4;
        end
        check_eq("glitch_out", 32'(acc_out), 32'h0);
        check_eq("glitch_rise", 32'(acc_rise), 32'h0);
        check_eq("glitch_fall", 32'(acc_fall), 32'h0);

        // Channel 1 goes high on its own, then reset lands mid-count on channel 0
        raw4 = 2'b10;
        tick(6);
        check_eq("ch1_out", 32'(out4), 32'h2);
        check_eq("ch1_rise", 32'(rise4), 32'h2);
        tick(1);
        raw4 = 2'b11;
        tick(4);
        check_eq("midcnt_out", 32'(out4), 32'h2);
        reset = 1'b0;
        #1;
        check_eq("midcnt_rst_out", 32'(out4), 32'h0);
        tick(2);
        check_eq("midcnt_rst_rise", 32'(rise4), 32'h0);
        check_eq("midcnt_rst_fall", 32'(fall4), 32'h0);
        reset = 1'b1;
        tick(5);
        check_eq("midcnt_out_e4", 32'(out4), 32'h0);
        tick(1);
        check_eq("midcnt_out_e5", 32'(out4), 32'h3);
        check_eq("midcnt_rise_e5", 32'(rise4), 32'h3);
        tick(1);
        check_eq("midcnt_rise_off", 32'(rise4), 32'h0);

        // One-sample filter: three-edge latency, one-cycle strobes
        raw1 = 2'b11;
        tick(2);
        check_eq("s1_out_e1", 32'(out1), 32'h0);
        tick(1);
        check_eq("s1_out", 32'(out1), 32'h3);
        check_eq("s1_rise", 32'(rise1), 32'h3);
        tick(1);
        check_eq("s1_rise_off", 32'(rise1), 32'h0);
        check_eq("s1_out_hold", 32'(out1), 32'h3);
        raw1 = 2'b00;
        tick(2);
        check_eq("s1_fall_e1", 32'(fall1), 32'h0);
        tick(1);
        check_eq("s1_fall_out", 32'(out1), 32'h0);
        check_eq("s1_fall", 32'(fall1), 32'h3);
        tick(1);
        check_eq("s1_fall_off", 32'(fall1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
